heap_pq_engine: RTL

Parametrised, sequential binary-heap priority queue that generalises the single-step pop/sift logic into a self-contained engine with push, pop and clear commands. It holds DEPTH entries of DATA_W bits in an internal register array, performs one compare-and-swap level per clock, and signals completion with a one-cycle response pulse. It sits between the sort front-end, which streams keys in, and the drain logic, which pops them out in priority order.

---
 rtl/heap_pkg.sv | 25 ++
 rtl/heap_child_select.sv | 40 ++++
 rtl/heap_pq_engine.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap priority-queue engine: op codes, FSM states, key ordering.
package heap_pkg;

    // Widest key the ordering helper accepts; callers zero-extend narrower keys.
    localparam int unsigned KEY_MAX_W = 64;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_RESP = 2'd3
    } heap_state_e;

    // True when key a belongs nearer the root than key b; strict, so equal keys never move.
    function automatic logic better(input logic min_heap,
                                    input logic [KEY_MAX_W-1:0] a,
                                    input logic [KEY_MAX_W-1:0] b);
        return min_heap ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/heap_child_select.sv
// Picks the best of a node and its two children for one sift-down level.
module heap_child_select #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 10,
    parameter bit          MIN_HEAP = 1'b1,
    parameter int unsigned IDX_W    = $clog2(DEPTH + 1)
) (
    input  logic [DATA_W-1:0] heap [DEPTH],
    input  logic [IDX_W-1:0]  idx,
    input  logic [IDX_W-1:0]  count,
    output logic [IDX_W-1:0]  best
);
    import heap_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    // Child indices carry one extra bit so 2*idx+2 never wraps.
    logic [IDX_W:0]      l;
    logic [IDX_W:0]      r;
    logic [DATA_W-1:0]   best_key;

    // Left child is tested first, so it wins a tie against the right child.
    always_comb begin
        l        = {idx, 1'b0} + (IDX_W + 1)'(1);
        r        = {idx, 1'b0} + (IDX_W + 1)'(2);
        best     = idx;
        best_key = heap[AW'(idx)];
        if ((l < {1'b0, count}) &&
            better(MIN_HEAP, KEY_MAX_W'(heap[AW'(l)]), KEY_MAX_W'(best_key))) begin
            best     = IDX_W'(l);
            best_key = heap[AW'(l)];
        end
        if ((r < {1'b0, count}) &&
            better(MIN_HEAP, KEY_MAX_W'(heap[AW'(r)]), KEY_MAX_W'(best_key))) begin
            best     = IDX_W'(r);
            best_key = heap[AW'(r)];
        end
    end

endmodule

// File: rtl/heap_pq_engine.sv
// Sequential binary-heap priority queue: push/pop/clear, one compare-and-swap level per clock.
module heap_pq_engine #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 10,
    parameter bit          MIN_HEAP = 1'b1,
    localparam int unsigned IDX_W   = $clog2(DEPTH + 1)
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [IDX_W-1:0]  count,
    output logic              empty,
    output logic              full
);
    import heap_pkg::*;

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    heap_state_e       state;
    heap_state_e       state_nx;
    logic [DATA_W-1:0] heap    [DEPTH];
    logic [DATA_W-1:0] heap_nx [DEPTH];
    logic [IDX_W-1:0]  count_nx;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nx;
    logic [IDX_W-1:0]  parent;
    logic [IDX_W-1:0]  best;
    logic [DATA_W-1:0] res_data;
    logic [DATA_W-1:0] res_data_nx;
    logic              res_err;
    logic              res_err_nx;

    assign cmd_ready = (state == ST_IDLE);
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_I);
    assign parent    = (idx - IDX_W'(1)) >> 1;

    heap_child_select #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .MIN_HEAP (MIN_HEAP),
        .IDX_W    (IDX_W)
    ) u_child_select (
        .heap  (heap),
        .idx   (idx),
        .count (count),
        .best  (best)
    );

    // State register.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) state <= ST_IDLE;
        else                state <= state_nx;
    end

    // Next state, command decode and swap muxing for the heap array.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        idx_nx      = idx;
        heap_nx     = heap;
        res_data_nx = res_data;
        res_err_nx  = res_err;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    res_data_nx = '0;
                    res_err_nx  = 1'b0;
                    state_nx    = ST_RESP;
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full) begin
                                res_err_nx = 1'b1;
                            end else begin
                                heap_nx[AW'(count)] = cmd_data;
                                count_nx            = count + IDX_W'(1);
                                idx_nx              = count;
                                state_nx            = ST_UP;
                            end
                        end
                        OP_POP: begin
                            if (empty) begin
                                res_err_nx = 1'b1;
                            end else begin
                                res_data_nx = heap[0];
                                heap_nx[0]  = heap[AW'(count - IDX_W'(1))];
                                count_nx    = count - IDX_W'(1);
                                idx_nx      = '0;
                                // A heap of zero or one remaining entries needs no sift.
                                if (count > IDX_W'(2)) state_nx = ST_DOWN;
                            end
                        end
                        OP_CLEAR: count_nx = '0;
                        default:  res_err_nx = 1'b1;
                    endcase
                end
            end
            ST_UP: begin
                if (idx == '0) begin
                    state_nx = ST_RESP;
                end else if (better(MIN_HEAP, KEY_MAX_W'(heap[AW'(idx)]),
                                    KEY_MAX_W'(heap[AW'(parent)]))) begin
                    heap_nx[AW'(idx)]    = heap[AW'(parent)];
                    heap_nx[AW'(parent)] = heap[AW'(idx)];
                    idx_nx               = parent;
                end else begin
                    state_nx = ST_RESP;
                end
            end
            ST_DOWN: begin
                if (best != idx) begin
                    heap_nx[AW'(idx)]  = heap[AW'(best)];
                    heap_nx[AW'(best)] = heap[AW'(idx)];
                    idx_nx             = best;
                end else begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath registers and the one-cycle response pulse.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            heap      <= '{default: '0};
            count     <= '0;
            idx       <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            heap      <= heap_nx;
            count     <= count_nx;
            idx       <= idx_nx;
            res_data  <= res_data_nx;
            res_err   <= res_err_nx;
            rsp_valid <= (state == ST_RESP);
            rsp_data  <= (state == ST_RESP) ? res_data : '0;
            rsp_err   <= (state == ST_RESP) && res_err;
        end
    end

endmodule
